// File: rtl/instr_encoder.sv
// instr_encoder: expands mnemonic commands into 9-bit words and writes them sequentially to imem.
// Build option: define INSTR_ENCODER_CHECK_EN to reject illegal ops and out-of-range shifts.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [7:0]        cmd_arg,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [8:0]        imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    typedef enum logic {
        st_idle,
        st_second
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [8:0]        wdata_q, wdata_d;
    logic [8:0]        hi_q, hi_d;

    logic              accept;
    logic              dec_emit, dec_second, dec_reject;
    logic [8:0]        dec_word, dec_hi;
    logic              emit;
    logic [8:0]        emit_word;

    assign cmd_ready = (state_q == st_idle) && !full_q && !clear;
    assign accept    = cmd_valid && cmd_ready;

    // Command decode; only meaningful when accept is high.
    always_comb begin
        dec_emit   = 1'b0;
        dec_second = 1'b0;
        dec_reject = 1'b0;
        dec_word   = '0;
        dec_hi     = '0;
        unique case (cmd_op[4:2])
            3'b000, 3'b001: begin
                dec_emit = 1'b1;
                dec_word = {2'b00, cmd_op[2:0], 1'b0, cmd_op[2:0]};
            end
            3'b010, 3'b011: begin
                if (cmd_op[2:0] == 3'd7) begin
                    // LI8 needs two free slots, regardless of build options.
                    if (count_q == LAST_CNT) begin
                        dec_reject = 1'b1;
                    end else begin
                        dec_emit   = 1'b1;
                        dec_second = 1'b1;
                        dec_word   = {2'b01, 3'b100, cmd_arg[3:0]};
                        dec_hi     = {2'b01, 3'b101, cmd_arg[7:4]};
                    end
                end else begin
                    dec_emit = 1'b1;
                    dec_word = {2'b01, cmd_op[2:0], cmd_arg[3:0]};
                end
            end
            3'b100: begin
                dec_emit = 1'b1;
                dec_word = {2'b10, cmd_op[1:0], cmd_arg[4:0]};
            end
            3'b101: begin
                if (!cmd_op[1]) begin
`ifdef INSTR_ENCODER_CHECK_EN
                    if (cmd_arg[4:3] != 2'b00) begin
                        dec_reject = 1'b1;
                    end else begin
                        dec_emit = 1'b1;
                        dec_word = {2'b11, cmd_op[1:0], cmd_arg[4:0]};
                    end
`else
                    dec_emit = 1'b1;
                    dec_word = {2'b11, cmd_op[1:0], 2'b00, cmd_arg[2:0]};
`endif
                end else begin
                    dec_emit = 1'b1;
                    dec_word = {2'b11, cmd_op[1:0], cmd_arg[4:0]};
                end
            end
            default: begin
`ifdef INSTR_ENCODER_CHECK_EN
                dec_reject = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        waddr_d   = waddr_q;
        count_d   = count_q;
        full_d    = full_q;
        err_d     = err_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;
        hi_d      = hi_q;
        emit      = 1'b0;
        emit_word = '0;

        if (clear) begin
            state_d = st_idle;
            ptr_d   = '0;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else if (state_q == st_second) begin
            emit      = 1'b1;
            emit_word = hi_q;
            state_d   = st_idle;
        end else if (accept) begin
            if (dec_reject) begin
                err_d = 1'b1;
            end else if (dec_emit) begin
                emit      = 1'b1;
                emit_word = dec_word;
                if (dec_second) begin
                    state_d = st_second;
                    hi_d    = dec_hi;
                end
            end
        end

        if (emit) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = emit_word;
            ptr_d   = ptr_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
            full_d  = (count_d == DEPTH_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= st_idle;
            ptr_q   <= '0;
            waddr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            waddr_q <= waddr_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios on 8-bit and 2-bit address instances,
// then randomized traffic against an arithmetic reference model.
module tb_instr_encoder;

    logic       clk;
    logic       rst_n;

    logic       b_clear, b_valid, b_ready, b_we, b_full, b_err;
    logic [4:0] b_op;
    logic [7:0] b_arg;
    logic [7:0] b_addr;
    logic [8:0] b_wdata;
    logic [8:0] b_count;

    logic       s_clear, s_valid, s_ready, s_we, s_full, s_err;
    logic [4:0] s_op;
    logic [7:0] s_arg;
    logic [1:0] s_addr;
    logic [8:0] s_wdata;
    logic [2:0] s_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder #(.ADDR_W(8)) u_big (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_arg(b_arg), .imem_we(b_we), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .count(b_count), .full(b_full), .err(b_err)
    );

    instr_encoder #(.ADDR_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .cmd_valid(s_valid), .cmd_ready(s_ready),
        .cmd_op(s_op), .cmd_arg(s_arg), .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .count(s_count), .full(s_full), .err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding from the word-format table, as plain arithmetic.
    task automatic encode_ref(input int op, input int arg, output int nw, output int w0,
                              output int w1, output bit rej);
        nw = 0; w0 = 0; w1 = 0; rej = 1'b0;
        if (op <= 7) begin
            nw = 1; w0 = op * 17;
        end else if (op <= 14) begin
            nw = 1; w0 = 128 + (op - 8) * 16 + arg % 16;
        end else if (op == 15) begin
            nw = 2; w0 = 192 + arg % 16; w1 = 208 + arg / 16;
        end else if (op <= 19) begin
            nw = 1; w0 = 256 + (op - 16) * 32 + arg % 32;
        end else if (op <= 21) begin
`ifdef INSTR_ENCODER_CHECK_EN
            if (arg % 32 > 7) rej = 1'b1;
            else begin nw = 1; w0 = 384 + (op - 20) * 32 + arg % 32; end
`else
            nw = 1; w0 = 384 + (op - 20) * 32 + arg % 8;
`endif
        end else if (op <= 23) begin
            nw = 1; w0 = 384 + (op - 20) * 32 + arg % 32;
        end else begin
`ifdef INSTR_ENCODER_CHECK_EN
            rej = 1'b1;
`endif
        end
    endtask

    task automatic b_clear_pulse();
        b_valid = 1'b0;
        b_clear = 1'b1;
        @(negedge clk);
        b_clear = 1'b0;
    endtask

    task automatic s_clear_pulse();
        s_valid = 1'b0;
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b_clear = 0; b_valid = 0; b_op = 0; b_arg = 0;
        s_clear = 0; s_valid = 0; s_op = 0; s_arg = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", b_ready); end
        n_checks++; if (b_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", b_we); end
        n_checks++; if (b_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", b_addr); end
        n_checks++; if (b_wdata !== 9'd0) begin n_fail++; $display("FAIL reset_wdata: got %b want 0", b_wdata); end
        n_checks++; if (b_count !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", b_count); end
        n_checks++; if (b_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", b_full); end
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", b_err); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_checks++; if (s_count !== 3'd0) begin n_fail++; $display("FAIL reset_s_count: got %0d want 0", s_count); end
    endtask

    task automatic test_add();
        b_valid = 1'b1; b_op = 5'd3; b_arg = 8'($urandom_range(255));
        @(negedge clk);
        b_valid = 1'b0;
        n_checks++; if (b_we !== 1'b1) begin n_fail++; $display("FAIL add_we: got %b want 1", b_we); end
        n_checks++; if (b_addr !== 8'd0) begin n_fail++; $display("FAIL add_addr: got %0d want 0", b_addr); end
        n_checks++; if (b_wdata !== 9'b000110011) begin n_fail++; $display("FAIL add_wdata: got %b want 000110011", b_wdata); end
        n_checks++; if (b_count !== 9'd1) begin n_fail++; $display("FAIL add_count: got %0d want 1", b_count); end
        @(negedge clk);
        n_checks++; if (b_we !== 1'b0) begin n_fail++; $display("FAIL add_idle_we: got %b want 0", b_we); end
    endtask

    task automatic test_li8();
        b_clear_pulse();
        b_valid = 1'b1; b_op = 5'd15; b_arg = 8'hA5;
        @(negedge clk);
        b_op = 5'd3; b_arg = 8'd0;
        #1;
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL li8_ready_second: got %b want 0", b_ready); end
        n_checks++; if (b_we !== 1'b1 || b_addr !== 8'd0) begin n_fail++; $display("FAIL li8_lo_addr: got we=%b addr=%0d want we=1 addr=0", b_we, b_addr); end
        n_checks++; if (b_wdata !== 9'b011000101) begin n_fail++; $display("FAIL li8_lo_word: got %b want 011000101", b_wdata); end
        @(negedge clk);
        #1;
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL li8_ready_back: got %b want 1", b_ready); end
        n_checks++; if (b_we !== 1'b1 || b_addr !== 8'd1) begin n_fail++; $display("FAIL li8_hi_addr: got we=%b addr=%0d want we=1 addr=1", b_we, b_addr); end
        n_checks++; if (b_wdata !== 9'b011011010) begin n_fail++; $display("FAIL li8_hi_word: got %b want 011011010", b_wdata); end
        n_checks++; if (b_count !== 9'd2) begin n_fail++; $display("FAIL li8_count: got %0d want 2", b_count); end
        @(negedge clk);
        b_valid = 1'b0;
        n_checks++; if (b_we !== 1'b1 || b_addr !== 8'd2 || b_wdata !== 9'b000110011) begin
            n_fail++; $display("FAIL li8_next_cmd: got we=%b addr=%0d word=%b want 1/2/000110011", b_we, b_addr, b_wdata);
        end
    endtask

    task automatic test_bun_lsl();
        b_clear_pulse();
        b_valid = 1'b1; b_op = 5'd19; b_arg = 8'h1F;
        @(negedge clk);
        b_op = 5'd20; b_arg = 8'd9;
        n_checks++; if (b_we !== 1'b1 || b_wdata !== 9'b101111111) begin n_fail++; $display("FAIL bun_word: got we=%b word=%b want 1/101111111", b_we, b_wdata); end
        @(negedge clk);
        b_valid = 1'b0;
`ifdef INSTR_ENCODER_CHECK_EN
        n_checks++; if (b_we !== 1'b0) begin n_fail++; $display("FAIL lsl_reject_we: got %b want 0", b_we); end
        n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL lsl_reject_err: got %b want 1", b_err); end
        n_checks++; if (b_count !== 9'd1) begin n_fail++; $display("FAIL lsl_reject_count: got %0d want 1", b_count); end
`else
        n_checks++; if (b_we !== 1'b1 || b_wdata !== 9'b110000001) begin n_fail++; $display("FAIL lsl_word: got we=%b word=%b want 1/110000001", b_we, b_wdata); end
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL lsl_err: got %b want 0", b_err); end
`endif
        b_clear_pulse();
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL bun_clear_err: got %b want 0", b_err); end
    endtask

    task automatic test_full_wrap();
        s_clear_pulse();
        s_valid = 1'b1; s_op = 5'd16; s_arg = 8'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_arg = 8'(i + 1);
            n_checks++;
            if (s_we !== 1'b1 || s_addr !== 2'(i) || s_wdata !== 9'(256 + i) || s_count !== 3'(i + 1)) begin
                n_fail++;
                $display("FAIL wrap_write%0d: got we=%b addr=%0d word=%b count=%0d want 1/%0d/%0d/%0d",
                         i, s_we, s_addr, s_wdata, s_count, i, 256 + i, i + 1);
            end
            n_checks++; if (s_full !== (i == 3)) begin n_fail++; $display("FAIL wrap_full%0d: got %b want %b", i, s_full, (i == 3)); end
        end
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_ready_full: got %b want 0", s_ready); end
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++; if (s_we !== 1'b0 || s_count !== 3'd4) begin n_fail++; $display("FAIL wrap_blocked: got we=%b count=%0d want 0/4", s_we, s_count); end
        s_clear_pulse();
        #1;
        n_checks++; if (s_count !== 3'd0 || s_full !== 1'b0 || s_we !== 1'b0) begin
            n_fail++; $display("FAIL wrap_clear: got count=%0d full=%b we=%b want 0/0/0", s_count, s_full, s_we);
        end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_clear_ready: got %b want 1", s_ready); end
        s_valid = 1'b1; s_op = 5'd16; s_arg = 8'd7;
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++; if (s_we !== 1'b1 || s_addr !== 2'd0 || s_wdata !== 9'd263) begin
            n_fail++; $display("FAIL wrap_restart: got we=%b addr=%0d word=%0d want 1/0/263", s_we, s_addr, s_wdata);
        end
    endtask

    task automatic test_li8_overflow();
        s_clear_pulse();
        s_valid = 1'b1; s_op = 5'd1; s_arg = 8'd0;
        repeat (3) @(negedge clk);
        s_op = 5'd15; s_arg = 8'($urandom_range(255));
        n_checks++; if (s_count !== 3'd3) begin n_fail++; $display("FAIL ovf_fill: got %0d want 3", s_count); end
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL ovf_we: got %b want 0", s_we); end
        n_checks++; if (s_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", s_err); end
        n_checks++; if (s_count !== 3'd3) begin n_fail++; $display("FAIL ovf_count: got %0d want 3", s_count); end
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready: got %b want 1", s_ready); end
        s_clear_pulse();
        n_checks++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_err: got %b want 0", s_err); end
    endtask

    task automatic test_clear_second();
        b_clear_pulse();
        b_valid = 1'b1; b_op = 5'd15; b_arg = 8'($urandom_range(255));
        @(negedge clk);
        b_valid = 1'b0; b_clear = 1'b1;
        n_checks++; if (b_we !== 1'b1 || b_count !== 9'd1) begin n_fail++; $display("FAIL clr2_lo: got we=%b count=%0d want 1/1", b_we, b_count); end
        @(negedge clk);
        b_clear = 1'b0;
        n_checks++; if (b_we !== 1'b0 || b_count !== 9'd0 || b_err !== 1'b0) begin
            n_fail++; $display("FAIL clr2_abort: got we=%b count=%0d err=%b want 0/0/0", b_we, b_count, b_err);
        end
        b_valid = 1'b1; b_op = 5'd15; b_arg = 8'h3C;
        @(negedge clk);
        b_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (b_we !== 1'b0 || b_count !== 9'd0) begin n_fail++; $display("FAIL rst2_abort: got we=%b count=%0d want 0/0", b_we, b_count); end
    endtask

    task automatic test_random();
        int  m_count, m_hi, e_addr, e_wdata, op, arg, nw, w0, w1;
        bit  m_err, m_pend, e_we, clr, vld, rdy, rej;
        b_clear_pulse();
        m_count = 0; m_err = 0; m_pend = 0; m_hi = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        for (int c = 0; c < 4000; c++) begin
            n_checks++; if (b_we !== e_we) begin n_fail++; $display("FAIL rnd_we c=%0d: got %b want %b", c, b_we, e_we); end
            if (e_we) begin
                n_checks++;
                if (b_addr !== 8'(e_addr) || b_wdata !== 9'(e_wdata)) begin
                    n_fail++; $display("FAIL rnd_word c=%0d: got addr=%0d word=%0d want %0d/%0d", c, b_addr, b_wdata, e_addr, e_wdata);
                end
            end
            n_checks++; if (b_count !== 9'(m_count)) begin n_fail++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, b_count, m_count); end
            n_checks++; if (b_full !== (m_count == 256)) begin n_fail++; $display("FAIL rnd_full c=%0d: got %b want %b", c, b_full, (m_count == 256)); end
            n_checks++; if (b_err !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d: got %b want %b", c, b_err, m_err); end

            clr = ($urandom_range(499) == 0);
            vld = ($urandom_range(9) < 7);
            op  = ($urandom_range(9) < 8) ? $urandom_range(23) : $urandom_range(31);
            arg = $urandom_range(255);
            b_clear = clr; b_valid = vld; b_op = 5'(op); b_arg = 8'(arg);
            #1;
            rdy = !m_pend && (m_count != 256) && !clr;
            n_checks++; if (b_ready !== rdy) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, b_ready, rdy); end

            e_we = 1'b0;
            if (clr) begin
                m_count = 0; m_err = 1'b0; m_pend = 1'b0;
            end else if (m_pend) begin
                e_we = 1'b1; e_addr = m_count % 256; e_wdata = m_hi; m_count++; m_pend = 1'b0;
            end else if (vld && rdy) begin
                encode_ref(op, arg, nw, w0, w1, rej);
                if (op == 15 && m_count == 255) m_err = 1'b1;
                else if (rej) m_err = 1'b1;
                else if (nw > 0) begin
                    e_we = 1'b1; e_addr = m_count % 256; e_wdata = w0; m_count++;
                    if (nw == 2) begin m_pend = 1'b1; m_hi = w1; end
                end
            end
            @(negedge clk);
        end
        b_valid = 1'b0; b_clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_add();
        test_li8();
        test_bun_lsl();
        test_full_wrap();
        test_li8_overflow();
        test_clear_second();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
